// File: rtl/sys1_pkg.sv
// sys1_pkg
//   Shared constants for the System 1/2 main-board sound mailbox:
//   request-mode and overflow-policy selectors, STATUS bit positions
//   and a depth sanity helper used at elaboration.
package sys1_pkg;

  localparam int REQ_PULSE     = 0;
  localparam int REQ_LEVEL     = 1;

  localparam int OVF_DROP      = 0;
  localparam int OVF_OVERWRITE = 1;

  localparam int STATUS_OVF_BIT   = 7;
  localparam int STATUS_FULL_BIT  = 6;
  localparam int STATUS_EMPTY_BIT = 5;
  localparam int STATUS_COUNT_MSB = 4;
  localparam int STATUS_COUNT_LSB = 0;

  // FIFO depth must be a power of two between 2 and 16 so the pointers
  // wrap naturally and COUNT fits in the 5-bit STATUS field.
  function automatic bit is_valid_depth(input int d);
    return (d >= 2) && (d <= 16) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/sys1_edge_det.sv
// sys1_edge_det
//   Rising-edge detector for a level strobe. A strobe held high for many
//   clocks produces a single-cycle 'rise' in the first cycle it is seen high.
//   Ports:
//     clk    in  system clock
//     rst    in  asynchronous active-high reset (clears the history)
//     in_sig in  strobe to qualify
//     rise   out in_sig & ~previous(in_sig), combinational
module sys1_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic in_sig,
  output logic rise
);

  logic in_q;
  logic in_d;

  always_comb begin
    in_d = in_sig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in_d;
    end
  end

  assign rise = in_sig & ~in_q;

endmodule

// File: rtl/sys1_sound_mailbox.sv
// sys1_sound_mailbox
//   Main-CPU to sound-CPU command mailbox: an edge-qualified DEPTH-entry
//   FIFO with pulse/level request and drop/overwrite overflow handling.
//   Ports:
//     CLK40M  in   system clock
//     RESET   in   asynchronous active-high reset
//     WR_EN   in   decoded main-CPU write strobe (may be held)
//     WR_DATA in   command byte, sampled in the push cycle
//     RD_ACK  in   sound-CPU command-read strobe (may be held)
//     FLUSH   in   synchronous clear of contents and OVF
//     SNDNO   out  head (oldest) command, holds last value while empty
//     SNDRQ   out  request to the sound CPU (pulse or level)
//     EMPTY   out  FIFO empty
//     FULL    out  FIFO full
//     OVF     out  sticky overflow
//     STATUS  out  {OVF, FULL, EMPTY, COUNT[4:0]}
module sys1_sound_mailbox
  import sys1_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4,
  parameter int REQ_MODE   = 0,
  parameter int OVF_POLICY = 0
) (
  input  logic              CLK40M,
  input  logic              RESET,
  input  logic              WR_EN,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              RD_ACK,
  input  logic              FLUSH,
  output logic [DATA_W-1:0] SNDNO,
  output logic              SNDRQ,
  output logic              EMPTY,
  output logic              FULL,
  output logic              OVF,
  output logic [7:0]        STATUS
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  if (!is_valid_depth(DEPTH)) begin : g_bad_depth
    $error("sys1_sound_mailbox: DEPTH must be a power of two in 2..16");
  end
  if ((REQ_MODE != REQ_PULSE) && (REQ_MODE != REQ_LEVEL)) begin : g_bad_req
    $error("sys1_sound_mailbox: REQ_MODE must be 0 or 1");
  end
  if ((OVF_POLICY != OVF_DROP) && (OVF_POLICY != OVF_OVERWRITE)) begin : g_bad_ovf
    $error("sys1_sound_mailbox: OVF_POLICY must be 0 or 1");
  end

  logic push;
  logic pop;

  sys1_edge_det u_wr_edge (
    .clk    (CLK40M),
    .rst    (RESET),
    .in_sig (WR_EN),
    .rise   (push)
  );

  sys1_edge_det u_rd_edge (
    .clk    (CLK40M),
    .rst    (RESET),
    .in_sig (RD_ACK),
    .rise   (pop)
  );

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] sndno_q, sndno_d;
  logic              sndrq_q, sndrq_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;

  logic [PTR_W-1:0]  rd_next;
  logic [PTR_W-1:0]  wr_next;
  logic              q_empty;
  logic              q_full;
  logic              pop_eff;
  logic              new_head;

  always_comb begin
    rd_next  = rd_ptr_q + 1'b1;
    wr_next  = wr_ptr_q + 1'b1;
    q_empty  = (count_q == '0);
    q_full   = (count_q == FULL_CNT);
    pop_eff  = pop & ~q_empty;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    sndno_d  = sndno_q;
    new_head = 1'b0;

    if (FLUSH) begin
      // Flush wins over any push/pop this cycle; SNDNO keeps its value.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else if (push && pop_eff) begin
      // Simultaneous push and pop: count is unchanged, even when full.
      // With a single entry the new head is the word being written now.
      mem_d[wr_ptr_q] = WR_DATA;
      wr_ptr_d = wr_next;
      rd_ptr_d = rd_next;
      sndno_d  = (count_q == ONE_CNT) ? WR_DATA : mem_q[rd_next];
      new_head = 1'b1;
    end else if (push && q_empty) begin
      mem_d[wr_ptr_q] = WR_DATA;
      wr_ptr_d = wr_next;
      count_d  = count_q + 1'b1;
      sndno_d  = WR_DATA;
      new_head = 1'b1;
    end else if (push && q_full) begin
      ovf_d = 1'b1;
      if (OVF_POLICY == OVF_OVERWRITE) begin
        // When full wr_ptr == rd_ptr, so the oldest slot is overwritten
        // and the next-oldest entry becomes head.
        mem_d[wr_ptr_q] = WR_DATA;
        wr_ptr_d = wr_next;
        rd_ptr_d = rd_next;
        sndno_d  = mem_q[rd_next];
        new_head = 1'b1;
      end
    end else if (push) begin
      mem_d[wr_ptr_q] = WR_DATA;
      wr_ptr_d = wr_next;
      count_d  = count_q + 1'b1;
    end else if (pop_eff) begin
      rd_ptr_d = rd_next;
      count_d  = count_q - 1'b1;
      if (count_q != ONE_CNT) begin
        sndno_d  = mem_q[rd_next];
        new_head = 1'b1;
      end
    end

    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);
    sndrq_d = (REQ_MODE == REQ_LEVEL) ? ~empty_d : new_head;
  end

  always_ff @(posedge CLK40M or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      sndno_q  <= '0;
      sndrq_q  <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      sndno_q  <= sndno_d;
      sndrq_q  <= sndrq_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  assign SNDNO = sndno_q;
  assign SNDRQ = sndrq_q;
  assign EMPTY = empty_q;
  assign FULL  = full_q;
  assign OVF   = ovf_q;

  always_comb begin
    STATUS = '0;
    STATUS[STATUS_OVF_BIT]   = ovf_q;
    STATUS[STATUS_FULL_BIT]  = full_q;
    STATUS[STATUS_EMPTY_BIT] = empty_q;
    STATUS[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 5'(count_q);
  end

endmodule

// File: tb/tb_sys1_sound_mailbox.sv
// tb_sys1_sound_mailbox
//   Directed bench for the sound mailbox. Three instances share clock and
//   reset but have private inputs:
//     0: REQ_PULSE, OVF_DROP
//     1: REQ_PULSE, OVF_OVERWRITE
//     2: REQ_LEVEL, OVF_DROP
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_sys1_sound_mailbox;

  logic       clk;
  logic       rst;
  logic       wr_en   [3];
  logic [7:0] wr_data [3];
  logic       rd_ack  [3];
  logic       flush   [3];
  logic [7:0] sndno   [3];
  logic       sndrq   [3];
  logic       empty   [3];
  logic       full    [3];
  logic       ovf     [3];
  logic [7:0] status  [3];

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sys1_sound_mailbox #(.DATA_W(8), .DEPTH(4), .REQ_MODE(0), .OVF_POLICY(0)) dut0 (
    .CLK40M(clk), .RESET(rst), .WR_EN(wr_en[0]), .WR_DATA(wr_data[0]),
    .RD_ACK(rd_ack[0]), .FLUSH(flush[0]), .SNDNO(sndno[0]), .SNDRQ(sndrq[0]),
    .EMPTY(empty[0]), .FULL(full[0]), .OVF(ovf[0]), .STATUS(status[0])
  );

  sys1_sound_mailbox #(.DATA_W(8), .DEPTH(4), .REQ_MODE(0), .OVF_POLICY(1)) dut1 (
    .CLK40M(clk), .RESET(rst), .WR_EN(wr_en[1]), .WR_DATA(wr_data[1]),
    .RD_ACK(rd_ack[1]), .FLUSH(flush[1]), .SNDNO(sndno[1]), .SNDRQ(sndrq[1]),
    .EMPTY(empty[1]), .FULL(full[1]), .OVF(ovf[1]), .STATUS(status[1])
  );

  sys1_sound_mailbox #(.DATA_W(8), .DEPTH(4), .REQ_MODE(1), .OVF_POLICY(0)) dut2 (
    .CLK40M(clk), .RESET(rst), .WR_EN(wr_en[2]), .WR_DATA(wr_data[2]),
    .RD_ACK(rd_ack[2]), .FLUSH(flush[2]), .SNDNO(sndno[2]), .SNDRQ(sndrq[2]),
    .EMPTY(empty[2]), .FULL(full[2]), .OVF(ovf[2]), .STATUS(status[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en[i]   = 1'b0;
      wr_data[i] = 8'h00;
      rd_ack[i]  = 1'b0;
      flush[i]   = 1'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // One write: strobe high for one clock then low for one clock.
  task automatic do_write(input int d, input logic [7:0] v);
    wr_data[d] = v;
    wr_en[d]   = 1'b1;
    tick();
    wr_en[d]   = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (status[d] !== 8'h20) begin
        n_fail++;
        $display("[TB] FAIL reset_status dut%0d: got %h expected 20", d, status[d]);
      end
      n_checks++;
      if ({sndno[d], sndrq[d], empty[d], full[d], ovf[d]} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs dut%0d: sndno=%h rq=%b e=%b f=%b o=%b expected 00 0 1 0 0",
                 d, sndno[d], sndrq[d], empty[d], full[d], ovf[d]);
      end
    end
  endtask

  task automatic test_single_write();
    int pulses;
    do_reset();
    wr_data[0] = 8'h5A;
    wr_en[0]   = 1'b1;
    tick();
    n_checks++;
    if (sndno[0] !== 8'h5A) begin
      n_fail++;
      $display("[TB] FAIL single_sndno: got %h expected 5a", sndno[0]);
    end
    n_checks++;
    if (status[0] !== 8'h01 || empty[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_status: got %h empty=%b expected 01 empty=0", status[0], empty[0]);
    end
    n_checks++;
    if (sndrq[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_rq_first: got %b expected 1", sndrq[0]);
    end
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (sndrq[0] === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("[TB] FAIL single_rq_extra: got %0d extra pulses expected 0", pulses);
    end
    n_checks++;
    if (status[0] !== 8'h01) begin
      n_fail++;
      $display("[TB] FAIL single_held_status: got %h expected 01", status[0]);
    end
    wr_en[0] = 1'b0;
    tick();
  endtask

  task automatic test_ovf_drop();
    logic [7:0] exp_head;
    do_reset();
    for (int i = 1; i <= 5; i++) do_write(0, 8'(i));
    n_checks++;
    if (status[0] !== 8'hC4 || ovf[0] !== 1'b1 || full[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL drop_status: got %h ovf=%b full=%b expected c4 1 1", status[0], ovf[0], full[0]);
    end
    for (int i = 1; i <= 4; i++) begin
      exp_head = 8'(i);
      n_checks++;
      if (sndno[0] !== exp_head) begin
        n_fail++;
        $display("[TB] FAIL drop_read%0d: got %h expected %h", i, sndno[0], exp_head);
      end
      rd_ack[0] = 1'b1;
      tick();
      n_checks++;
      if (sndrq[0] !== ((i < 4) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("[TB] FAIL drop_rq%0d: got %b expected %b", i, sndrq[0], (i < 4));
      end
      rd_ack[0] = 1'b0;
      tick();
    end
    n_checks++;
    if (status[0] !== 8'hA0 || sndno[0] !== 8'h04) begin
      n_fail++;
      $display("[TB] FAIL drop_drained: got status %h sndno %h expected a0 04", status[0], sndno[0]);
    end
  endtask

  task automatic test_ovf_overwrite();
    logic [7:0] exp_head;
    do_reset();
    for (int i = 1; i <= 4; i++) do_write(1, 8'(i));
    wr_data[1] = 8'h05;
    wr_en[1]   = 1'b1;
    tick();
    n_checks++;
    if (sndrq[1] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ovw_rq: got %b expected 1", sndrq[1]);
    end
    n_checks++;
    if (sndno[1] !== 8'h02 || status[1] !== 8'hC4) begin
      n_fail++;
      $display("[TB] FAIL ovw_state: got sndno %h status %h expected 02 c4", sndno[1], status[1]);
    end
    wr_en[1] = 1'b0;
    tick();
    for (int i = 2; i <= 5; i++) begin
      exp_head = 8'(i);
      n_checks++;
      if (sndno[1] !== exp_head) begin
        n_fail++;
        $display("[TB] FAIL ovw_read%0d: got %h expected %h", i, sndno[1], exp_head);
      end
      rd_ack[1] = 1'b1;
      tick();
      rd_ack[1] = 1'b0;
      tick();
    end
    n_checks++;
    if (status[1] !== 8'hA0) begin
      n_fail++;
      $display("[TB] FAIL ovw_drained: got %h expected a0", status[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_tbl [4];
    exp_tbl[0] = 8'h11; exp_tbl[1] = 8'h12; exp_tbl[2] = 8'h13; exp_tbl[3] = 8'h20;
    do_reset();
    for (int i = 0; i < 4; i++) do_write(0, 8'h10 + 8'(i));
    wr_data[0] = 8'h20;
    wr_en[0]   = 1'b1;
    rd_ack[0]  = 1'b1;
    tick();
    n_checks++;
    if (sndno[0] !== 8'h11 || status[0] !== 8'h44 || sndrq[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pushpop_full: got sndno %h status %h rq %b expected 11 44 1",
               sndno[0], status[0], sndrq[0]);
    end
    wr_en[0]  = 1'b0;
    rd_ack[0] = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (sndno[0] !== exp_tbl[i]) begin
        n_fail++;
        $display("[TB] FAIL pushpop_read%0d: got %h expected %h", i, sndno[0], exp_tbl[i]);
      end
      rd_ack[0] = 1'b1;
      tick();
      rd_ack[0] = 1'b0;
      tick();
    end
    n_checks++;
    if (status[0] !== 8'h20) begin
      n_fail++;
      $display("[TB] FAIL pushpop_drained: got %h expected 20", status[0]);
    end
  endtask

  task automatic test_level();
    do_reset();
    do_write(2, 8'hAA);
    do_write(2, 8'hBB);
    n_checks++;
    if (sndrq[2] !== 1'b1 || status[2] !== 8'h02) begin
      n_fail++;
      $display("[TB] FAIL level_two: got rq %b status %h expected 1 02", sndrq[2], status[2]);
    end
    rd_ack[2] = 1'b1;
    tick();
    n_checks++;
    if (sndrq[2] !== 1'b1 || sndno[2] !== 8'hBB) begin
      n_fail++;
      $display("[TB] FAIL level_ack1: got rq %b sndno %h expected 1 bb", sndrq[2], sndno[2]);
    end
    rd_ack[2] = 1'b0;
    tick();
    n_checks++;
    if (sndrq[2] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL level_between: got %b expected 1", sndrq[2]);
    end
    rd_ack[2] = 1'b1;
    tick();
    n_checks++;
    if (sndrq[2] !== 1'b0 || empty[2] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL level_ack2: got rq %b empty %b expected 0 1", sndrq[2], empty[2]);
    end
    rd_ack[2] = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 1; i <= 5; i++) do_write(0, 8'(i));
    flush[0]   = 1'b1;
    wr_data[0] = 8'h44;
    wr_en[0]   = 1'b1;
    tick();
    n_checks++;
    if (status[0] !== 8'h20 || ovf[0] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_status: got %h ovf %b expected 20 0", status[0], ovf[0]);
    end
    n_checks++;
    if (sndno[0] !== 8'h01) begin
      n_fail++;
      $display("[TB] FAIL flush_sndno: got %h expected 01", sndno[0]);
    end
    flush[0] = 1'b0;
    wr_en[0] = 1'b0;
    tick();
    rd_ack[0] = 1'b1;
    tick();
    n_checks++;
    if (status[0] !== 8'h20 || sndrq[0] !== 1'b0 || sndno[0] !== 8'h01) begin
      n_fail++;
      $display("[TB] FAIL flush_ack_empty: got status %h rq %b sndno %h expected 20 0 01",
               status[0], sndrq[0], sndno[0]);
    end
    rd_ack[0] = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en[i]   = 1'b0;
      wr_data[i] = 8'h00;
      rd_ack[i]  = 1'b0;
      flush[i]   = 1'b0;
    end
    test_reset();
    test_single_write();
    test_ovf_drop();
    test_ovf_overwrite();
    test_back_to_back();
    test_level();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sys1_sound_mailbox.md
# sys1_sound_mailbox

Parametrised main-CPU → sound-CPU command mailbox for the System 1/2 main board. It replaces the single-entry sound-number latch and one-cycle request pulse with an edge-qualified, DEPTH-entry FIFO. The FIFO has a configurable request mode, a configurable overflow policy and status readback. The block sits between the main CPU's port-$14/$18 write decode and the sound CPU's command-read/NMI logic.

## Interface
- DATA_W, default 8: command width.
- DEPTH, default 4: FIFO entries; power of two, 2..16.
- REQ_MODE, default 0: 0 = pulse request (REQ_PULSE), 1 = level request (REQ_LEVEL).
- OVF_POLICY, default 0: 0 = drop the incoming write (OVF_DROP), 1 = overwrite the oldest entry (OVF_OVERWRITE).
- CLK40M  in  1  system clock; all state is on the rising edge.
- RESET  in  1  asynchronous, active-high.
- WR_EN  in  1  main-CPU write strobe, already decoded (iorq & wr & port match); may stay high for many clocks.
- WR_DATA  in  DATA_W  command byte (CPUDO).
- RD_ACK  in  1  sound-CPU command-read strobe; may stay high for many clocks.
- FLUSH  in  1  synchronous clear of FIFO contents and OVF; level-sensitive.
- SNDNO  out  DATA_W  head entry (oldest command).
- SNDRQ  out  1  request to the sound CPU.
- EMPTY  out  1  FIFO empty.
- FULL  out  1  FIFO full.
- OVF  out  1  sticky overflow.
- STATUS  out  8  {OVF, FULL, EMPTY, COUNT[4:0]}; COUNT is zero-extended.

## Operation
- Reset values: SNDNO=0, SNDRQ=0, EMPTY=1, FULL=0, OVF=0, COUNT=0, pointers=0, edge-detector history=0.
- Rising-edge qualification:
  - push = WR_EN & ~WR_EN_q.
  - pop = RD_ACK & ~RD_ACK_q.
  - A held strobe yields exactly one event.
- WR_DATA is sampled in the push cycle.
- Pop on empty is ignored.
- Push and pop in the same cycle:
  - empty: push only.
  - partially filled: both occur, COUNT unchanged.
  - full: both occur, no overflow.
- Push when full with no pop:
  - OVF_DROP: data is discarded and OVF is set.
  - OVF_OVERWRITE: the oldest entry is discarded (read pointer advances), the new data is written, COUNT stays DEPTH and OVF is set.
- OVF stays set until FLUSH or RESET.
- FLUSH has priority over push and pop in the same cycle. It zeroes the pointers, COUNT and OVF, and the push/pop in that cycle is lost. SNDNO is not cleared.
- SNDNO shows the head entry, and holds its last value while empty.
- SNDRQ in REQ_LEVEL mode equals ~EMPTY.
- SNDRQ in REQ_PULSE mode is high for one clock whenever a new entry becomes head:
  - a push into an empty FIFO;
  - a pop leaving the FIFO non-empty;
  - an overwrite at full (the head changes).
- Arithmetic:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - COUNT is log2(DEPTH)+1 bits.
  - FULL = (COUNT==DEPTH); EMPTY = (COUNT==0).

## Timing
- The push/pop event is combinational from strobe and history. FIFO state, SNDNO, SNDRQ and the flags all update at the next rising edge, so latency is 1 clock from the first high sample of a strobe.
- The SNDRQ pulse is coincident with the first cycle in which the new SNDNO is valid.
- Back-to-back events need the strobe to drop for at least one clock. At 4 MHz Z80 timing the strobes are low for ≥5 clocks, which meets this.
- All outputs are registered except STATUS, which is concatenated from registered flags.
- RESET during a held strobe: the history is cleared, so a strobe still high after release registers as a new edge. Accepted behaviour.

## Structure
- Shared package sys1_pkg holds REQ_PULSE, REQ_LEVEL, OVF_DROP, OVF_OVERWRITE and the STATUS bit positions.
- One sub-module, sys1_edge_det (rising-edge detector with async reset), is instantiated for WR_EN and RD_ACK.
- Storage is a register array of DEPTH × DATA_W, not BRAM.
- Elaboration-time check: DEPTH is a power of two in 2..16.

## Test plan
- Reset then a single write of $5A held for 8 clocks:
  - one push only; SNDNO=$5A, EMPTY=0, STATUS=$01 one clock after the rising edge;
  - REQ_PULSE: SNDRQ high for exactly 1 clock.
- DEPTH=4, OVF_DROP: write $01..$05, then ack 4 times.
  - After the writes: OVF=1, FULL=1, STATUS=$C4.
  - The acks read SNDNO sequence $01,$02,$03,$04, then EMPTY=1.
- DEPTH=4, OVF_OVERWRITE: write $01..$05.
  - SNDNO=$02, COUNT=4, OVF=1.
  - An extra SNDRQ pulse occurs in the overwrite cycle.
- Push and pop rising in the same cycle on a full FIFO holding $10..$13 with WR_DATA=$20:
  - SNDNO=$11, COUNT=4, OVF=0;
  - later pops read $11,$12,$13,$20.
- REQ_LEVEL with 2 entries:
  - SNDRQ stays high across the first ack and falls 1 clock after the second ack edge.
- FLUSH asserted together with a push edge:
  - COUNT=0, OVF=0, push lost.
  - Ack on empty afterwards: no state change, SNDRQ stays 0.
